control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock in 1 (rising-edge); clear in 1 (active-low, asynchronous; 0 = reset).
REQ-002 Inputs SHALL be: IR in 32 (instruction register contents from datapath); mem_ready in 1 (memory read data valid on Mdatain).
REQ-003 Outputs SHALL be: Rin out 16 and Rout out 16 (one-hot register strobes); PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, IncPC, Read out 1 each.
REQ-004 Further outputs SHALL be: Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin out 1 each; ALUop out 4; Run out 1 (1 = executing, 0 = halted).

Function
REQ-005 IR fields SHALL be: opcode = IR[31:27], Ra = IR[26:23] (destination), Rb = IR[22:19], Rc = IR[18:15].
REQ-006 States SHALL be T0, T1, T2, T3, T4, T5, T6 and HALT, held in a registered state variable.
REQ-007 Outputs SHALL be decoded combinationally from the state and IR, and every output not listed for a state SHALL be 0.
REQ-008 T0 SHALL assert PCout, MARin, IncPC and Zlowin, then go to T1.
REQ-009 T1 SHALL assert Zlowout, PCin, Read and MDRin, and SHALL remain in T1 while mem_ready=0.
REQ-010 PCin SHALL be asserted only in the first T1 cycle, so the PC is incremented exactly once per fetch; T1 SHALL go to T2 when mem_ready=1.
REQ-011 T2 SHALL assert MDRout and IRin, then go to T3.
REQ-012 ALU opcodes 00000-01011 SHALL execute as follows.
- T3: Rout[Rb], Yin.
- T4: Rout[Rc], Zlowin, ALUop = opcode[3:0].
- T5: Zlowout, Rin[Ra].
- Then go to T0.
REQ-013 SUB (opcode 00100) SHALL therefore drive ALUop = 4'd4 in T4.
REQ-014 Opcode 11011 (HALT) SHALL go from T3 to HALT; HALT SHALL drive Run=0 with all strobes 0, and only reset exits HALT.
REQ-015 Any other opcode SHALL be a NOP: T3 with no strobes asserted, then go to T0.
REQ-016 Ra, Rb and Rc SHALL each select exactly one bit of Rin/Rout (bit index = field value), and R0 SHALL be a legal target.
REQ-017 Run SHALL be 1 in every state except HALT.
REQ-018 Each instruction SHALL take 6 cycles for ALU ops with mem_ready tied 1, and 4 cycles for NOP.

Reset
REQ-019 When clear=0, the state SHALL go asynchronously to T0 and every output SHALL be 0, including Run.
REQ-020 On the first rising clock edge after clear returns to 1, state SHALL still be T0, T0 outputs SHALL appear, and Run SHALL be 1.
REQ-021 Reset asserted mid-instruction (any state, including T1 wait and HALT) SHALL abort the instruction with no further strobes.

Configuration
REQ-022 The macro SHALL be named MULDIV_EN.
REQ-023 With MULDIV_EN defined, opcodes 01100 (MUL) and 01101 (DIV) SHALL execute as follows.
- T3: Rout[Rb], Yin.
- T4: Rout[Rc], Zlowin, Zhighin, ALUop = opcode[3:0].
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
- Then go to T0.
REQ-024 Without MULDIV_EN, opcodes 01100/01101 SHALL be NOPs, T6 SHALL be unreachable, and Zhighin, Zhighout and HIin SHALL be tied 0.

Verification
REQ-025 Reset then run: clear=0 for 2 cycles, then 1 -> all outputs 0 during reset; T0 strobes (PCout, MARin, IncPC, Zlowin) on the first cycle; Run=1.
REQ-026 SUB: IR=0x212B0000 (sub R2,R5,R6), mem_ready=1 -> T3 Rout=0x0020 with Yin; T4 Rout=0x0040 with ALUop=4 and Zlowin; T5 Rin=0x0004 with Zlowout; back to T0 after 6 cycles total.
REQ-027 Memory stall: mem_ready=0 for 3 cycles in T1 -> T1 held for 4 cycles, PCin asserted only in the first of them, Read=MDRin=1 throughout; T2 follows the cycle mem_ready=1.
REQ-028 HALT: IR=0xD8000000 -> HALT entered after T3, Run=0, all strobes 0 for 10 further cycles; clear pulse -> T0, Run=1.
REQ-029 MULDIV_EN: IR=0x612B0000 (mul R2,R5,R6) -> T4 with Zlowin=Zhighin=1 and ALUop=12; T5 LOin; T6 HIin; without the macro, the same IR -> NOP, back to T0 after T3.
REQ-030 Reset mid-T4 of a SUB -> outputs 0 immediately, Rin[2] never asserted, restart at T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: 6 cycles per ALU op, 4 per NOP, 7 per MUL/DIV; outputs combinational from state+IR.
// mem_ready=0 holds T1 (PCin only on its first cycle); `define MULDIV_EN enables MUL/DIV with LO/HI writeback.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [3:0]  ALUop,
    output logic        Run
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

    state_t state;
    state_t next_state;
    logic   t1_wait;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu;
    logic       is_muldiv;
    logic       is_halt;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];
    assign is_alu    = (opcode <= 5'd11);
    assign is_halt   = (opcode == 5'd27);
`ifdef MULDIV_EN
    assign is_muldiv = (opcode == 5'd12) || (opcode == 5'd13);
`else
    assign is_muldiv = 1'b0;
`endif

    // t1_wait marks every T1 cycle after the first, so PCin fires once per fetch.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= T0;
            t1_wait <= 1'b0;
        end else begin
            state   <= next_state;
            t1_wait <= (state == T1) && (next_state == T1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            T0:      next_state = T1;
            T1:      next_state = mem_ready ? T2 : T1;
            T2:      next_state = T3;
            T3: begin
                if (is_alu || is_muldiv) next_state = T4;
                else if (is_halt)        next_state = HALT;
                else                     next_state = T0;
            end
            T4:      next_state = T5;
            T5:      next_state = is_muldiv ? T6 : T0;
            T6:      next_state = T0;
            HALT:    next_state = HALT;
            default: next_state = T0;
        endcase
    end

    always_comb begin
        Rin      = 16'd0;
        Rout     = 16'd0;
        PCin     = 1'b0;
        PCout    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ALUop    = 4'd0;
        Run      = 1'b0;
        // Gating on clear makes every output drop the instant reset asserts.
        if (clear) begin
            Run = (state != HALT);
            case (state)
                T0: begin
                    PCout  = 1'b1;
                    MARin  = 1'b1;
                    IncPC  = 1'b1;
                    Zlowin = 1'b1;
                end
                T1: begin
                    Zlowout = 1'b1;
                    PCin    = !t1_wait;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                T3: begin
                    if (is_alu || is_muldiv) begin
                        Rout = 16'd1 << rb;
                        Yin  = 1'b1;
                    end
                end
                T4: begin
                    Rout    = 16'd1 << rc;
                    Zlowin  = 1'b1;
                    Zhighin = is_muldiv;
                    ALUop   = opcode[3:0];
                end
                T5: begin
                    Zlowout = 1'b1;
                    if (is_muldiv) LOin = 1'b1;
                    else           Rin  = 16'd1 << ra;
                end
`ifdef MULDIV_EN
                T6: begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: an instruction-level model expands each instruction into its expected per-cycle output trace.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic [15:0] Rin, Rout;
    logic PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, IncPC, Read;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Run;
    logic [3:0]  ALUop;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcin, pcout, marin, mdrin, mdrout, irin, yin, incpc, read;
        logic zlowin, zhighin, zlowout, zhighout, hiin, loin;
        logic [3:0] aluop;
        logic run;
    } outs_t;

    typedef struct packed {
        logic  mr;
        outs_t o;
    } cyc_t;

`ifdef MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    outs_t dut_o;
    cyc_t  seq_q[$];
    int    tests = 0;
    int    fails = 0;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
        .Read(Read), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .ALUop(ALUop), .Run(Run)
    );

    assign dut_o = {Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, IncPC, Read,
                    Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, ALUop, Run};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_o(input string nm, input outs_t act, input outs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic mr, input outs_t o);
        cyc_t c;
        c.mr = mr;
        c.o  = o;
        seq_q.push_back(c);
    endtask

    // Expected trace for one instruction: fetch with `stall` wait cycles, then execute; halt_n idle HALT cycles.
    task automatic build(input logic [31:0] ir, input int stall, input int halt_n);
        outs_t      o;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        seq_q.delete();
        o = '0; o.run = 1; o.pcout = 1; o.marin = 1; o.incpc = 1; o.zlowin = 1;
        push(1'b1, o);
        for (int i = 0; i <= stall; i++) begin
            o = '0; o.run = 1; o.zlowout = 1; o.read = 1; o.mdrin = 1; o.pcin = (i == 0);
            push(i == stall, o);
        end
        o = '0; o.run = 1; o.mdrout = 1; o.irin = 1;
        push(1'b1, o);
        if (op <= 5'd11 || (MULDIV && (op == 5'd12 || op == 5'd13))) begin
            o = '0; o.run = 1; o.rout[rb] = 1; o.yin = 1;
            push(1'b1, o);
            o = '0; o.run = 1; o.rout[rc] = 1; o.zlowin = 1; o.zhighin = (op >= 5'd12); o.aluop = op[3:0];
            push(1'b1, o);
            if (op <= 5'd11) begin
                o = '0; o.run = 1; o.zlowout = 1; o.rin[ra] = 1;
                push(1'b1, o);
            end else begin
                o = '0; o.run = 1; o.zlowout = 1; o.loin = 1;
                push(1'b1, o);
                o = '0; o.run = 1; o.zhighout = 1; o.hiin = 1;
                push(1'b1, o);
            end
        end else begin
            o = '0; o.run = 1;
            push(1'b1, o);
            if (op == 5'd27)
                for (int i = 0; i < halt_n; i++) push(1'b1, '0);
        end
    endtask

    // Called at posedge+1 of the instruction's T0 cycle; returns at posedge+1 after the last cycle.
    task automatic run_seq(input string nm, input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = seq_q[i];
            mem_ready = c.mr;
            @(negedge clock);
            check_o($sformatf("%s[%0d]", nm, i), dut_o, c.o);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_reset(input string nm, input int cycles);
        clear = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check_o($sformatf("%s_zero[%0d]", nm, i), dut_o, '0);
        end
        @(posedge clock);
        #1;
        clear = 1'b1;
    endtask

    initial begin
        clear     = 1'b0;
        mem_ready = 1'b1;
        IR        = 32'h212B0000;
        #1;
        check_o("reset_async_zero", dut_o, '0);
        pulse_reset("reset", 2);

        // sub R2,R5,R6
        build(32'h212B0000, 0, 0);
        check_int("sub_len", seq_q.size(), 6);
        check_int("sub_t0_pcout", int'(seq_q[0].o.pcout), 1);
        check_int("sub_t3_rout", int'(seq_q[3].o.rout), 32'h0020);
        check_int("sub_t4_rout", int'(seq_q[4].o.rout), 32'h0040);
        check_int("sub_t4_aluop", int'(seq_q[4].o.aluop), 4);
        check_int("sub_t5_rin", int'(seq_q[5].o.rin), 32'h0004);
        run_seq("sub", seq_q.size());

        // add R0,R15,R1 with a 3-cycle memory stall
        IR = 32'h18788000;
        build(IR, 3, 0);
        check_int("stall_len", seq_q.size(), 9);
        check_int("stall_pcin_first", int'(seq_q[1].o.pcin), 1);
        check_int("stall_pcin_later", int'(seq_q[2].o.pcin), 0);
        check_int("add_r0_rin", int'(seq_q[8].o.rin), 1);
        run_seq("add_stall", seq_q.size());

        // opcode 01011, highest plain ALU op, R15/R0 fields
        IR = 32'h5F878000;
        build(IR, 0, 0);
        check_int("op11_aluop", int'(seq_q[4].o.aluop), 11);
        run_seq("op11", seq_q.size());

        // NOP (opcode 01110)
        IR = 32'h70000000;
        build(IR, 0, 0);
        check_int("nop_len", seq_q.size(), 4);
        run_seq("nop", seq_q.size());

        // MUL / DIV: full op with MULDIV_EN, NOP without
        IR = 32'h612B0000;
        build(IR, 0, 0);
        check_int("mul_len", seq_q.size(), MULDIV ? 7 : 4);
        run_seq("mul", seq_q.size());
        IR = 32'h692B0000;
        build(IR, 1, 0);
        run_seq("div", seq_q.size());

        // Reset in T4 of a SUB: strobes vanish at once, Rin never fires, fetch restarts
        IR = 32'h212B0000;
        build(IR, 0, 0);
        run_seq("sub_abort", 4);
        mem_ready = 1'b1;
        @(negedge clock);
        check_o("sub_abort_t4", dut_o, seq_q[4].o);
        #1;
        clear = 1'b0;
        #1;
        check_o("abort_async_zero", dut_o, '0);
        @(negedge clock);
        check_o("abort_hold_zero", dut_o, '0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        run_seq("sub_restart", seq_q.size());

        // HALT: stays halted for 10 cycles, only reset exits
        IR = 32'hD8000000;
        build(IR, 0, 10);
        check_int("halt_len", seq_q.size(), 14);
        check_int("halt_run", int'(seq_q[13].o.run), 0);
        run_seq("halt", seq_q.size());
        pulse_reset("halt_clear", 1);
        IR = 32'h212B0000;
        build(IR, 0, 0);
        run_seq("after_halt", seq_q.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
